// File: rtl/debug_report_pkg.sv
// Shared types and constants for the debug report transmitter.
package debug_report_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoadWord,
    StWaitRd,
    StSend,
    StWaitTx,
    StSendChk,
    StWaitChk,
    StDone
  } state_e;

  // Which part of the frame is currently being streamed.
  typedef enum logic [2:0] {
    SecHdr,
    SecPc,
    SecCnt,
    SecReg,
    SecMem,
    SecChk
  } section_e;

  localparam logic [7:0] HEADER_BYTE = 8'hA5;

  // BYTES_PER_WORD = BITS_SIZE / SIZE_TRAMA for a given width pair.
  function automatic int unsigned bytes_per_word(input int unsigned bits_size,
                                                 input int unsigned size_trama);
    return bits_size / size_trama;
  endfunction

endpackage

// File: rtl/report_word_shifter.sv
// Holds one word and presents it MSB byte first, one byte per advance.
module report_word_shifter
  import debug_report_pkg::*;
#(
  parameter int unsigned Width = 32,
  parameter int unsigned ByteW = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             advance_i,
  input  logic [Width-1:0] word_i,
  output logic [ByteW-1:0] byte_o,
  output logic             last_o
);

  localparam int unsigned NumBytes = bytes_per_word(Width, ByteW);
  localparam int unsigned CntW     = (NumBytes > 1) ? $clog2(NumBytes) : 1;

  logic [Width-1:0] word_q;
  logic [CntW-1:0]  idx_q;

  // Load wins over advance; advance moves the next byte into the MSB slot.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      word_q <= '0;
      idx_q  <= '0;
    end else if (load_i) begin
      word_q <= word_i;
      idx_q  <= '0;
    end else if (advance_i) begin
      word_q <= {word_q[Width-ByteW-1:0], {ByteW{1'b0}}};
      idx_q  <= idx_q + CntW'(1);
    end
  end

  assign byte_o = word_q[Width-1 -: ByteW];
  assign last_o = (idx_q == CntW'(NumBytes - 1));

endmodule

// File: rtl/debug_report_tx.sv
// Streams a framed MIPS state dump (header, PC, cycle count, registers,
// memory window, XOR checksum) to the UART transmitter.
module debug_report_tx #(
  parameter int unsigned           BITS_SIZE     = 32,
  parameter int unsigned           SIZE_TRAMA    = 8,
  parameter int unsigned           NUM_REGS      = 32,
  parameter int unsigned           NUM_MEM_WORDS = 32,
  parameter logic [SIZE_TRAMA-1:0] HEADER_BYTE   = SIZE_TRAMA'(debug_report_pkg::HEADER_BYTE)
) (
  input  logic                             i_clk,
  input  logic                             i_reset,
  input  logic                             i_start,
  input  logic [BITS_SIZE-1:0]             i_pc,
  input  logic [BITS_SIZE-1:0]             i_clk_count,
  output logic [$clog2(NUM_REGS)-1:0]      o_select_reg_dir,
  input  logic [BITS_SIZE-1:0]             i_reg_data,
  output logic [$clog2(NUM_MEM_WORDS)-1:0] o_select_mem_dir,
  input  logic [BITS_SIZE-1:0]             i_mem_data,
  input  logic                             i_uart_tx_done,
  output logic                             o_uart_tx_start,
  output logic [SIZE_TRAMA-1:0]            o_uart_tx_data,
  output logic                             o_busy,
  output logic                             o_done
);

  import debug_report_pkg::*;

  localparam int unsigned RegAw = $clog2(NUM_REGS);
  localparam int unsigned MemAw = $clog2(NUM_MEM_WORDS);
  localparam logic [RegAw-1:0] RegLast = RegAw'(NUM_REGS - 1);
  localparam logic [MemAw-1:0] MemLast = MemAw'(NUM_MEM_WORDS - 1);

  state_e                state_q;
  section_e              sect_q;
  logic [BITS_SIZE-1:0]  pc_q, cnt_q;
  logic [RegAw-1:0]      reg_idx_q;
  logic [MemAw-1:0]      mem_idx_q;
  logic [SIZE_TRAMA-1:0] chk_q;
  logic                  start_q, busy_q, done_q;

  logic                  sh_load, sh_adv, sh_last;
  logic [BITS_SIZE-1:0]  sh_word;
  logic [SIZE_TRAMA-1:0] sh_byte;

  report_word_shifter #(
    .Width (BITS_SIZE),
    .ByteW (SIZE_TRAMA)
  ) u_shifter (
    .clk_i     (i_clk),
    .rst_ni    (i_reset),
    .load_i    (sh_load),
    .advance_i (sh_adv),
    .word_i    (sh_word),
    .byte_o    (sh_byte),
    .last_o    (sh_last)
  );

  // Shifter control: snapshot words load straight out of WAIT_TX, RAM words after the read wait.
  always_comb begin
    sh_load = 1'b0;
    sh_adv  = 1'b0;
    sh_word = '0;
    if (state_q == StWaitRd) begin
      sh_load = 1'b1;
      sh_word = (sect_q == SecReg) ? i_reg_data : i_mem_data;
    end else if (state_q == StWaitTx && i_uart_tx_done) begin
      if (sect_q == SecHdr) begin
        sh_load = 1'b1;
        sh_word = pc_q;
      end else if (!sh_last) begin
        sh_adv = 1'b1;
      end else if (sect_q == SecPc) begin
        sh_load = 1'b1;
        sh_word = cnt_q;
      end
    end
  end

  // Frame sequencer; tx_start is high exactly while in SEND / SEND_CHK.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q   <= StIdle;
      sect_q    <= SecHdr;
      pc_q      <= '0;
      cnt_q     <= '0;
      reg_idx_q <= '0;
      mem_idx_q <= '0;
      chk_q     <= '0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      start_q <= 1'b0;
      done_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (i_start) begin
            pc_q    <= i_pc;
            cnt_q   <= i_clk_count;
            chk_q   <= '0;
            sect_q  <= SecHdr;
            busy_q  <= 1'b1;
            start_q <= 1'b1;
            state_q <= StSend;
          end
        end
        StLoadWord: state_q <= StWaitRd;
        StWaitRd: begin
          start_q <= 1'b1;
          state_q <= StSend;
        end
        StSend: begin
          if (sect_q != SecHdr) chk_q <= chk_q ^ sh_byte;
          state_q <= StWaitTx;
        end
        StWaitTx: begin
          if (i_uart_tx_done) begin
            if (sect_q == SecHdr) begin
              sect_q  <= SecPc;
              start_q <= 1'b1;
              state_q <= StSend;
            end else if (!sh_last) begin
              start_q <= 1'b1;
              state_q <= StSend;
            end else begin
              case (sect_q)
                SecPc: begin
                  sect_q  <= SecCnt;
                  start_q <= 1'b1;
                  state_q <= StSend;
                end
                SecCnt: begin
                  sect_q    <= SecReg;
                  reg_idx_q <= '0;
                  state_q   <= StLoadWord;
                end
                SecReg: begin
                  if (reg_idx_q == RegLast) begin
                    sect_q    <= SecMem;
                    mem_idx_q <= '0;
                  end else begin
                    reg_idx_q <= reg_idx_q + RegAw'(1);
                  end
                  state_q <= StLoadWord;
                end
                SecMem: begin
                  if (mem_idx_q == MemLast) begin
                    sect_q  <= SecChk;
                    start_q <= 1'b1;
                    state_q <= StSendChk;
                  end else begin
                    mem_idx_q <= mem_idx_q + MemAw'(1);
                    state_q   <= StLoadWord;
                  end
                end
                default: state_q <= StIdle;
              endcase
            end
          end
        end
        StSendChk: state_q <= StWaitChk;
        StWaitChk: begin
          if (i_uart_tx_done) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StDone;
          end
        end
        StDone: begin
          reg_idx_q <= '0;
          mem_idx_q <= '0;
          sect_q    <= SecHdr;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Byte mux over registered sources; forced to zero whenever no frame is in flight.
  always_comb begin
    o_uart_tx_data = '0;
    if (busy_q) begin
      case (sect_q)
        SecHdr:  o_uart_tx_data = HEADER_BYTE;
        SecChk:  o_uart_tx_data = chk_q;
        default: o_uart_tx_data = sh_byte;
      endcase
    end
  end

  assign o_uart_tx_start  = start_q;
  assign o_busy           = busy_q;
  assign o_done           = done_q;
  assign o_select_reg_dir = reg_idx_q;
  assign o_select_mem_dir = mem_idx_q;

endmodule

// File: tb/tb_debug_report_tx.sv
// Directed bench for debug_report_tx with a UART responder and registered-read RAMs.
module tb_debug_report_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] pc = '0;
  logic [31:0] clk_count = '0;
  logic [4:0]  reg_addr, mem_addr;
  logic [31:0] reg_data, mem_data;
  logic        tx_done = 1'b0;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        busy, done;

  logic [31:0] regs [32];
  logic [31:0] mems [32];
  logic [31:0] reg_q = '0;
  logic [31:0] mem_q = '0;

  // Written only by the initial block.
  int unsigned tx_delay = 5;
  int          long_at = -1;
  logic        garble = 1'b0;
  logic        spurious = 1'b0;
  int          flush_req = 0;

  // Written only by the UART responder.
  logic [7:0]  rx_bytes [$];
  logic        pending = 1'b0;
  logic [7:0]  held = '0;
  int unsigned wait_cnt = 0;
  int unsigned cur_delay = 5;
  int          n_starts = 0;
  int          n_done = 0;
  int          proto_err = 0;
  int          flush_seen = 0;
  logic        last_real = 1'b0;

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  debug_report_tx dut (
    .i_clk            (clk),
    .i_reset          (rst_n),
    .i_start          (start),
    .i_pc             (pc),
    .i_clk_count      (clk_count),
    .o_select_reg_dir (reg_addr),
    .i_reg_data       (reg_data),
    .o_select_mem_dir (mem_addr),
    .i_mem_data       (mem_data),
    .i_uart_tx_done   (tx_done),
    .o_uart_tx_start  (tx_start),
    .o_uart_tx_data   (tx_data),
    .o_busy           (busy),
    .o_done           (done)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAMs; garbage is presented while a byte is on the wire.
  always @(posedge clk) begin
    reg_q <= regs[reg_addr];
    mem_q <= mems[mem_addr];
  end
  assign reg_data = (garble && pending) ? ~reg_q : reg_q;
  assign mem_data = (garble && pending) ? ~mem_q : mem_q;

  // UART responder: records bytes, checks hold/overlap, pulses tx_done after a delay.
  always @(negedge clk) begin
    logic spur;
    spur = spurious && last_real;
    tx_done = 1'b0;
    last_real = 1'b0;
    if (flush_req != flush_seen) begin
      flush_seen = flush_req;
      pending = 1'b0;
    end else begin
      if (done) n_done++;
      if (tx_start) begin
        if (pending) proto_err++;
        cur_delay = (rx_bytes.size() == long_at) ? 1000 : tx_delay;
        rx_bytes.push_back(tx_data);
        held = tx_data;
        pending = 1'b1;
        wait_cnt = 0;
        n_starts++;
      end else if (pending) begin
        if (tx_data !== held) proto_err++;
        wait_cnt++;
        if (wait_cnt >= cur_delay) begin
          tx_done = 1'b1;
          pending = 1'b0;
          last_real = 1'b1;
        end
      end
      if (spur) tx_done = 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
    cyc++;
  endtask

  // Mismatch count of the recorded frame starting at base against an independently built one.
  function automatic int frame_errors(int base, logic [31:0] pc_v, logic [31:0] cnt_v);
    logic [7:0] e [$];
    logic [7:0] chk;
    int errs;
    e.push_back(8'hA5);
    for (int b = 3; b >= 0; b--) e.push_back(pc_v[b*8 +: 8]);
    for (int b = 3; b >= 0; b--) e.push_back(cnt_v[b*8 +: 8]);
    for (int r = 0; r < 32; r++) for (int b = 3; b >= 0; b--) e.push_back(regs[r][b*8 +: 8]);
    for (int m = 0; m < 32; m++) for (int b = 3; b >= 0; b--) e.push_back(mems[m][b*8 +: 8]);
    chk = '0;
    for (int i = 1; i < e.size(); i++) chk ^= e[i];
    e.push_back(chk);
    errs = 0;
    if (rx_bytes.size() - base != e.size()) errs++;
    for (int i = 0; i < e.size(); i++) begin
      if (base + i >= rx_bytes.size()) errs++;
      else if (rx_bytes[base + i] !== e[i]) errs++;
    end
    return errs;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    step();
    step();
    checks++;
    if ({tx_start, busy, done} !== 3'b000)
      $display("FAIL reset_ctrl: got %b expected 000", {tx_start, busy, done});
    else passes++;
    checks++;
    if (tx_data !== 8'h00) $display("FAIL reset_data: got %h expected 00", tx_data);
    else passes++;
    checks++;
    if ({reg_addr, mem_addr} !== 10'h000)
      $display("FAIL reset_addr: got %h expected 000", {reg_addr, mem_addr});
    else passes++;
    rst_n = 1'b1;
    step();
    step();
    checks++;
    if ({tx_start, busy} !== 2'b00) $display("FAIL idle_quiet: got %b expected 00", {tx_start, busy});
    else passes++;
  endtask

  task automatic test_basic_frame();
    logic [7:0] lead [0:8] = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h40, 8'h00, 8'h00, 8'h01, 8'h23};
    int base, d0, e0, n;
    pc = 32'h0000_0040;
    clk_count = 32'h0000_0123;
    base = rx_bytes.size();
    d0 = n_done;
    e0 = proto_err;
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if ({tx_start, busy} !== 2'b11) $display("FAIL start_latency: got %b expected 11", {tx_start, busy});
    else passes++;
    checks++;
    if (tx_data !== 8'hA5) $display("FAIL header_byte: got %h expected a5", tx_data);
    else passes++;
    for (int c = 0; c < 6000 && n_done == d0; c++) step();
    checks++;
    if (n_done != d0 + 1) $display("FAIL basic_done: got %0d expected %0d", n_done - d0, 1);
    else passes++;
    n = rx_bytes.size() - base;
    checks++;
    if (n != 266) $display("FAIL basic_len: got %0d expected 266", n);
    else passes++;
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (rx_bytes[base + i] !== lead[i])
        $display("FAIL lead_byte%0d: got %h expected %h", i, rx_bytes[base + i], lead[i]);
      else passes++;
    end
    checks++;
    if (rx_bytes[base + 32] !== 8'h05) $display("FAIL reg5_lsb: got %h expected 05", rx_bytes[base + 32]);
    else passes++;
    checks++;
    if (rx_bytes[base + 137] !== 8'hFF) $display("FAIL mem0_msb: got %h expected ff", rx_bytes[base + 137]);
    else passes++;
    checks++;
    if (rx_bytes[base + 265] !== 8'h62) $display("FAIL checksum: got %h expected 62", rx_bytes[base + 265]);
    else passes++;
    checks++;
    n = frame_errors(base, 32'h0000_0040, 32'h0000_0123);
    if (n != 0) $display("FAIL basic_frame: got %0d bad bytes expected 0", n);
    else passes++;
    checks++;
    if (proto_err != e0) $display("FAIL basic_proto: got %0d errors expected 0", proto_err - e0);
    else passes++;
    checks++;
    if ({busy, done} !== 2'b00) $display("FAIL basic_idle: got %b expected 00", {busy, done});
    else passes++;
  endtask

  task automatic test_read_timing();
    int base, d0, t0, t1, n;
    logic [4:0] prev;
    garble = 1'b1;
    pc = 32'h0;
    clk_count = 32'h0;
    base = rx_bytes.size();
    d0 = n_done;
    t0 = -1;
    t1 = -1;
    prev = reg_addr;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 3000 && t0 < 0; c++) begin
      step();
      if (prev == 5'd4 && reg_addr == 5'd5) t0 = cyc;
      prev = reg_addr;
    end
    for (int c = 0; c < 100 && t1 < 0 && t0 >= 0; c++) begin
      step();
      if (tx_start) t1 = cyc;
    end
    checks++;
    if (t0 < 0 || t1 - t0 != 2) $display("FAIL addr_to_start: got %0d expected 2", t1 - t0);
    else passes++;
    for (int c = 0; c < 6000 && n_done == d0; c++) step();
    garble = 1'b0;
    checks++;
    n = frame_errors(base, 32'h0, 32'h0);
    if (n != 0) $display("FAIL capture_window: got %0d bad bytes expected 0", n);
    else passes++;
  endtask

  task automatic test_pc_snapshot();
    int base, d0, n;
    pc = 32'h1234_5678;
    clk_count = 32'hCAFE_0001;
    base = rx_bytes.size();
    d0 = n_done;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 6000 && n_done == d0; c++) begin
      pc = $urandom;
      clk_count = $urandom;
      step();
    end
    checks++;
    if (rx_bytes[base + 1] !== 8'h12 || rx_bytes[base + 4] !== 8'h78)
      $display("FAIL pc_snapshot: got %h..%h expected 12..78", rx_bytes[base + 1], rx_bytes[base + 4]);
    else passes++;
    checks++;
    n = frame_errors(base, 32'h1234_5678, 32'hCAFE_0001);
    if (n != 0) $display("FAIL snapshot_frame: got %0d bad bytes expected 0", n);
    else passes++;
  endtask

  task automatic test_start_ignored();
    int d0, s0;
    pc = 32'h0;
    clk_count = 32'h0;
    d0 = n_done;
    s0 = n_starts;
    start = 1'b1;
    for (int c = 0; c < 6000 && n_done == d0; c++) step();
    start = 1'b0;
    for (int c = 0; c < 20; c++) step();
    checks++;
    if (n_starts - s0 != 266) $display("FAIL start_busy_bytes: got %0d expected 266", n_starts - s0);
    else passes++;
    checks++;
    if (n_done - d0 != 1) $display("FAIL start_busy_done: got %0d expected 1", n_done - d0);
    else passes++;
    checks++;
    if (busy !== 1'b0) $display("FAIL start_busy_idle: got %b expected 0", busy);
    else passes++;
  endtask

  task automatic test_long_delay();
    int base, d0, e0, s0, n;
    pc = 32'h0;
    clk_count = 32'h0;
    base = rx_bytes.size();
    long_at = base + 20;
    spurious = 1'b1;
    d0 = n_done;
    e0 = proto_err;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 3000 && rx_bytes.size() - base < 21; c++) step();
    s0 = n_starts;
    for (int c = 0; c < 500; c++) step();
    checks++;
    if (tx_data !== 8'h02) $display("FAIL long_hold_data: got %h expected 02", tx_data);
    else passes++;
    checks++;
    if (n_starts != s0) $display("FAIL long_no_start: got %0d extra expected 0", n_starts - s0);
    else passes++;
    for (int c = 0; c < 6000 && n_done == d0; c++) step();
    spurious = 1'b0;
    long_at = -1;
    checks++;
    n = frame_errors(base, 32'h0, 32'h0);
    if (n != 0) $display("FAIL long_frame: got %0d bad bytes expected 0", n);
    else passes++;
    checks++;
    if (proto_err != e0) $display("FAIL long_proto: got %0d errors expected 0", proto_err - e0);
    else passes++;
  endtask

  task automatic test_reset_midframe();
    int base, d0, s0, n;
    pc = 32'h0000_0040;
    clk_count = 32'h0000_0123;
    base = rx_bytes.size();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 500 && rx_bytes.size() - base < 10; c++) step();
    rst_n = 1'b0;
    flush_req++;
    step();
    checks++;
    if ({tx_start, busy, done, tx_data, reg_addr, mem_addr} !== 21'h0)
      $display("FAIL midframe_reset: got %h expected 0",
               {tx_start, busy, done, tx_data, reg_addr, mem_addr});
    else passes++;
    s0 = n_starts;
    rst_n = 1'b1;
    for (int c = 0; c < 50; c++) step();
    checks++;
    if (n_starts != s0) $display("FAIL abort_no_start: got %0d expected 0", n_starts - s0);
    else passes++;
    base = rx_bytes.size();
    d0 = n_done;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 6000 && n_done == d0; c++) step();
    checks++;
    n = frame_errors(base, 32'h0000_0040, 32'h0000_0123);
    if (n != 0) $display("FAIL post_reset_frame: got %0d bad bytes expected 0", n);
    else passes++;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      regs[i] = 32'(i);
      mems[i] = 32'hFFFF_0000 | 32'(i);
    end
    test_reset();
    test_basic_frame();
    test_read_timing();
    test_pc_snapshot();
    test_start_ignored();
    test_long_delay();
    test_reset_midframe();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/debug_report_tx.md
Name: debug_report_tx

Overview:
Transmit-side counterpart of the debug command receiver. On a dump request it snapshots MIPS state and streams a framed byte report to the UART transmitter: PC, clock-cycle count, all register-file words, then a data-memory window. It sits between the debug unit (request/select side) and the UART TX path (start/done handshake), clocked by the same wizard clock.

Parameters:
BITS_SIZE, 32, width of PC, count, register and memory words (multiple of SIZE_TRAMA)
SIZE_TRAMA, 8, UART frame payload width
NUM_REGS, 32, register-file words dumped
NUM_MEM_WORDS, 32, data-memory words dumped from address 0
HEADER_BYTE, 8'hA5, frame start marker

Ports:
i_clk  in  1  system clock
i_reset  in  1  synchronous, active-low reset
i_start  in  1  dump request; sampled only in IDLE
i_pc  in  BITS_SIZE  current PC; latched at start
i_clk_count  in  BITS_SIZE  executed-cycle counter; latched at start
o_select_reg_dir  out  clog2(NUM_REGS)  register-file read address
i_reg_data  in  BITS_SIZE  register word; valid 1 cycle after address
o_select_mem_dir  out  clog2(NUM_MEM_WORDS)  data-memory word address
i_mem_data  in  BITS_SIZE  memory word; valid 1 cycle after address
i_uart_tx_done  in  1  one-cycle pulse: current byte fully sent
o_uart_tx_start  out  1  one-cycle pulse: send o_uart_tx_data
o_uart_tx_data  out  SIZE_TRAMA  byte to send; stable from start pulse until tx_done
o_busy  out  1  high from start acceptance until frame done
o_done  out  1  one-cycle pulse after checksum byte's tx_done

Behaviour:
- Reset (i_reset==0 at posedge): state IDLE; all outputs 0; indices, checksum and snapshot registers cleared. Reset mid-frame aborts; no resume, no further tx_start.
- Frame: HEADER, PC (BITS_SIZE/8 bytes, MSB first), clk_count (MSB first), NUM_REGS words (reg 0 upward, MSB first each), NUM_MEM_WORDS words (addr 0 upward), CHECKSUM. Defaults: 1+4+4+128+128+1 = 266 bytes.
- CHECKSUM = XOR of every byte after HEADER, up to and excluding itself.
- States: IDLE -> LOAD_WORD -> WAIT_RD -> SEND -> WAIT_TX -> (SEND | LOAD_WORD | SEND_CHK) ; SEND_CHK -> WAIT_CHK -> DONE -> IDLE.
- IDLE: i_start==1 latches i_pc, i_clk_count; next cycle o_busy=1, o_uart_tx_start=1, o_uart_tx_data=HEADER (cycle N start -> N+1 pulse).
- HEADER/PC/count words come from snapshot registers, no read wait (WAIT_RD skipped).
- Reg/mem words: LOAD_WORD drives address; WAIT_RD one cycle; word captured into shift register on following edge; then SEND.
- SEND: o_uart_tx_start high exactly one cycle; byte updated into checksum at same edge.
- WAIT_TX: hold o_uart_tx_data; wait indefinitely for i_uart_tx_done. tx_done outside WAIT_TX/WAIT_CHK ignored. On tx_done: next byte of same word -> SEND next cycle; last byte -> advance word index -> LOAD_WORD; last mem word -> SEND_CHK.
- Address outputs hold last value between reads; return to 0 in IDLE.
- DONE: o_done pulse 1 cycle, o_busy drops same cycle; next cycle IDLE. i_start during busy/DONE ignored (not queued).
- Index counters sized for NUM_REGS/NUM_MEM_WORDS exactly; terminal compare at NUM-1, no wrap into next section.
- Snapshot values stable for whole frame even if i_pc/i_clk_count change.

Decomposition:
- Package debug_report_pkg: state encoding, section encoding (HDR, PC, CNT, REG, MEM, CHK), HEADER_BYTE, BYTES_PER_WORD = BITS_SIZE/SIZE_TRAMA.
- Sub-module report_word_shifter: loads one BITS_SIZE word, presents MSB byte, shifts on advance, flags last byte.

Test Plan:
- Reset low mid-frame after 10 bytes -> all outputs 0 next cycle, no further tx_start; subsequent start sends full 266-byte frame.
- PC=32'h0000_0040, count=32'h0000_0123, regs[i]=i, mem[j]=32'hFFFF_0000|j, tx_done 5 cycles after each start -> bytes A5,00,00,00,40,00,00,01,23, reg/mem bytes MSB first, correct XOR checksum, one o_done.
- Check read timing: address change to word capture = 2 edges; changing i_reg_data outside capture cycle has no effect.
- i_pc changed every cycle during frame -> transmitted PC equals value at start cycle.
- i_start asserted while busy and during DONE -> ignored; exactly one frame.
- tx_done delayed 1000 cycles on one byte -> o_uart_tx_data stable, no second tx_start; tx_done pulse while in LOAD_WORD ignored.
